// File: rtl/stage_mem.sv
// Memory stage: turns an EX/MEM load or store into one or two word-aligned data-memory
// accesses (two when the access straddles a word boundary) and returns an extended load result.
module stage_mem #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EX_MEM_valid,
  input  logic                 EX_MEM_mem_read,
  input  logic                 EX_MEM_mem_write,
  input  logic [REG_WIDTH-1:0] EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0] EX_MEM_dataB,
  input  logic [2:0]           EX_MEM_funct3,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [REG_WIDTH-3:0] dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [REG_WIDTH-1:0] dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [REG_WIDTH-1:0] dmem_rdata,
  output logic                 mem_stall,
  output logic [REG_WIDTH-1:0] load_data,
  output logic                 load_valid,
  output logic                 access_err,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  // Handshake: a request is presented with dmem_req=1 and its addr/be/we/wdata held
  // stable; it completes in the cycle dmem_ack=1, and dmem_rdata is only sampled then.
  logic                 start;
  logic [1:0]           off_in;
  logic [1:0]           size_in;
  logic [3:0]           size_mask;
  logic [7:0]           be_wide;
  logic [63:0]          wdata_wide;
  logic                 span_in;

  logic [1:0]           off_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic                 load_q;
  logic                 span_q;
  logic [3:0]           be_hi_q;
  logic [REG_WIDTH-1:0] wdata_hi_q;
  logic [REG_WIDTH-1:0] rd1_q;

  logic [REG_WIDTH-1:0] asm_lo;
  logic [REG_WIDTH-1:0] asm_hi;
  logic [REG_WIDTH-1:0] raw;
  logic [REG_WIDTH-1:0] load_next;

  function automatic logic [31:0] extend_load(input logic [31:0] r, input logic [1:0] size,
                                              input logic uns);
    case (size)
      2'b00:   return uns ? {24'b0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
      2'b01:   return uns ? {16'b0, r[15:0]} : {{16{r[15]}}, r[15:0]};
      default: return r;
    endcase
  endfunction

  always_comb begin
    start     = (state == IDLE) && EX_MEM_valid && (EX_MEM_mem_read || EX_MEM_mem_write);
    off_in    = EX_MEM_alu_out[1:0];
    size_in   = EX_MEM_funct3[1:0];
    size_mask = 4'b1111;
    case (size_in)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    // Shifting into a double-width lane gives both access halves at once:
    // the low word feeds the first access, the high word the second.
    be_wide    = {4'b0000, size_mask} << off_in;
    wdata_wide = {32'b0, EX_MEM_dataB} << {off_in, 3'b000};
    span_in    = ((size_in == 2'b01) && (off_in == 2'd3)) ||
                 ((size_in == 2'b10) && (off_in != 2'd0));
  end

  always_comb begin
    asm_lo    = (state == ACC2) ? rd1_q : dmem_rdata;
    asm_hi    = (state == ACC2) ? dmem_rdata : '0;
    raw       = 32'({asm_hi, asm_lo} >> {off_q, 3'b000});
    load_next = extend_load(raw, size_q, uns_q);
  end

  assign mem_stall = !reset && (start || (state == ACC1) || (state == ACC2));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      access_err <= 1'b0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      load_q     <= 1'b0;
      span_q     <= 1'b0;
      be_hi_q    <= '0;
      wdata_hi_q <= '0;
      rd1_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          load_valid <= 1'b0;
          access_err <= 1'b0;
          if (start) begin
            off_q      <= off_in;
            size_q     <= size_in;
            uns_q      <= EX_MEM_funct3[2];
            load_q     <= EX_MEM_mem_read;
            span_q     <= span_in;
            be_hi_q    <= be_wide[7:4];
            wdata_hi_q <= wdata_wide[63:32];
            if (size_in == 2'b11) begin
              access_err <= 1'b1;
              state      <= DONE;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= EX_MEM_mem_write && !EX_MEM_mem_read;
              dmem_addr  <= EX_MEM_alu_out[31:2];
              dmem_be    <= be_wide[3:0];
              dmem_wdata <= wdata_wide[31:0];
              state      <= ACC1;
            end
          end
        end
        ACC1: begin
          if (dmem_ack) begin
            if (span_q) begin
              rd1_q      <= dmem_rdata;
              dmem_addr  <= dmem_addr + 30'd1;
              dmem_be    <= be_hi_q;
              dmem_wdata <= wdata_hi_q;
              state      <= ACC2;
            end else begin
              dmem_req   <= 1'b0;
              dmem_we    <= 1'b0;
              load_valid <= load_q;
              if (load_q) load_data <= load_next;
              state      <= DONE;
            end
          end
        end
        ACC2: begin
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            load_valid <= load_q;
            if (load_q) load_data <= load_next;
            state      <= DONE;
          end
        end
        DONE: begin
          load_valid <= 1'b0;
          access_err <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: driver issues EX/MEM instructions and plays the memory,
// a negedge monitor pops expected requests, loads and errors from queues.
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_MEM_valid;
  logic        EX_MEM_mem_read;
  logic        EX_MEM_mem_write;
  logic [31:0] EX_MEM_alu_out;
  logic [31:0] EX_MEM_dataB;
  logic [2:0]  EX_MEM_funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;
  logic [1:0]  state_dbg;

  int checks = 0;
  int passes = 0;

  logic [66:0] req_exp_q[$];
  logic [31:0] load_exp_q[$];
  logic [31:0] err_exp_q[$];

  stage_mem #(.REG_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .EX_MEM_valid(EX_MEM_valid), .EX_MEM_mem_read(EX_MEM_mem_read),
    .EX_MEM_mem_write(EX_MEM_mem_write), .EX_MEM_alu_out(EX_MEM_alu_out),
    .EX_MEM_dataB(EX_MEM_dataB), .EX_MEM_funct3(EX_MEM_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
    .access_err(access_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic note_unexpected(input string name, input logic [66:0] act);
    checks++;
    $display("FAIL %s: got %h expected no event", name, act);
  endtask

  task automatic push_req(input logic we, input logic [29:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    req_exp_q.push_back({we, addr, be, wdata});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (dmem_req && dmem_ack) begin
      if (req_exp_q.size() == 0) note_unexpected("dmem_req", {dmem_we, dmem_addr, dmem_be, dmem_wdata});
      else check("dmem_req", {dmem_we, dmem_addr, dmem_be, dmem_wdata}, req_exp_q.pop_front());
    end
    if (load_valid) begin
      if (load_exp_q.size() == 0) note_unexpected("load_valid", load_data);
      else check("load_data", load_data, load_exp_q.pop_front());
    end
    if (access_err) begin
      if (err_exp_q.size() == 0) note_unexpected("access_err", EX_MEM_alu_out);
      else check("access_err_addr", EX_MEM_alu_out, err_exp_q.pop_front());
    end
  end

  // driver: issue one instruction and act as memory (w = wait cycles before ack)
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int w1, input logic [31:0] r1, input int w2,
                        input logic [31:0] r2, input int exp_stall);
    int phase = 0;
    int reqcnt = 0;
    int stall = 0;
    bit done = 0;
    @(posedge clk); #1;
    EX_MEM_valid = 1'b1; EX_MEM_mem_read = rd; EX_MEM_mem_write = wr;
    EX_MEM_funct3 = f3; EX_MEM_alu_out = addr; EX_MEM_dataB = data;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (dmem_req) begin
        if (reqcnt == ((phase == 0) ? w1 : w2)) begin
          dmem_ack = 1'b1; dmem_rdata = (phase == 0) ? r1 : r2;
          phase++; reqcnt = 0;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom; reqcnt++;
        end
      end else begin
        dmem_ack = 1'b1; dmem_rdata = $urandom;
      end
      #1;
      if (mem_stall) stall++;
      else done = 1;
      if (!done) begin @(posedge clk); #1; end
    end
    check("access_done", done, 1'b1);
    check("stall_cycles", stall, exp_stall);
    @(posedge clk); #1;
    EX_MEM_valid = 1'b0; EX_MEM_mem_read = 1'b0; EX_MEM_mem_write = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; EX_MEM_valid = 1'b1; EX_MEM_mem_read = 1'b1; EX_MEM_mem_write = 1'b0;
    EX_MEM_alu_out = 32'h100; EX_MEM_dataB = 32'h0; EX_MEM_funct3 = 3'b010;
    dmem_ack = 1'b1; dmem_rdata = 32'h0;
    @(posedge clk); #1;
    check("stall_in_reset", mem_stall, 1'b0);
    @(posedge clk); #1;
    check("reset_req_we", {dmem_req, dmem_we}, 2'b00);
    check("reset_addr_be", {dmem_addr, dmem_be}, 34'h0);
    check("reset_wdata", dmem_wdata, 32'h0);
    check("reset_load", {load_valid, access_err, load_data}, 34'h0);
    check("reset_state", state_dbg, 2'd0);
    EX_MEM_valid = 1'b0; dmem_ack = 1'b0;
    reset = 1'b0;

    // no live instruction: nothing happens
    EX_MEM_mem_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("idle_quiet", {mem_stall, dmem_req}, 2'b00);
    end
    EX_MEM_mem_read = 1'b0;

    // LW 0x100, ack on second request cycle
    push_req(1'b0, 30'h40, 4'hf, 32'h0); load_exp_q.push_back(32'hDEADBEEF);
    access(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0, 3);
    // LB / LBU 0x103
    push_req(1'b0, 30'h40, 4'h8, 32'h0); load_exp_q.push_back(32'hFFFFFF80);
    access(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80000000, 0, 32'h0, 2);
    push_req(1'b0, 30'h40, 4'h8, 32'h0); load_exp_q.push_back(32'h00000080);
    access(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80000000, 0, 32'h0, 2);
    // SW 0x102 spanning
    push_req(1'b1, 30'h40, 4'hc, 32'h33440000); push_req(1'b1, 30'h41, 4'h3, 32'h00001122);
    access(0, 1, 3'b010, 32'h102, 32'h11223344, 0, 32'h0, 0, 32'h0, 3);
    // LH 0x7 spanning, signed
    push_req(1'b0, 30'h1, 4'h8, 32'h0); push_req(1'b0, 30'h2, 4'h1, 32'h0);
    load_exp_q.push_back(32'hFFFFCDAB);
    access(1, 0, 3'b001, 32'h7, 32'h0, 0, 32'hAB000000, 0, 32'h000000CD, 3);
    // illegal size
    err_exp_q.push_back(32'h100);
    access(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    // SH 0x101
    push_req(1'b1, 30'h40, 4'h6, 32'hAA567800);
    access(0, 1, 3'b001, 32'h101, 32'hAAAA5678, 0, 32'h0, 0, 32'h0, 2);
    // SW 0xFFFFFFFF: second word wraps to 0
    push_req(1'b1, 30'h3FFFFFFF, 4'h8, 32'hD4000000); push_req(1'b1, 30'h0, 4'h7, 32'h00A1B2C3);
    access(0, 1, 3'b010, 32'hFFFFFFFF, 32'hA1B2C3D4, 2, 32'h0, 1, 32'h0, 6);
    // LHU 0x7 with waits
    push_req(1'b0, 30'h1, 4'h8, 32'h0); push_req(1'b0, 30'h2, 4'h1, 32'h0);
    load_exp_q.push_back(32'h0000CDAB);
    access(1, 0, 3'b101, 32'h7, 32'h0, 1, 32'hAB000000, 0, 32'h000000CD, 4);
    // LW 0x101 spanning
    push_req(1'b0, 30'h40, 4'he, 32'h0); push_req(1'b0, 30'h41, 4'h1, 32'h0);
    load_exp_q.push_back(32'h88112233);
    access(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h11223344, 0, 32'h55667788, 3);
    // read and write both high behaves as load
    push_req(1'b0, 30'h2, 4'hf, 32'hCAFEF00D); load_exp_q.push_back(32'h12345678);
    access(1, 1, 3'b010, 32'h8, 32'hCAFEF00D, 0, 32'h12345678, 0, 32'h0, 2);
    // LH 0x2, positive
    push_req(1'b0, 30'h0, 4'hc, 32'h0); load_exp_q.push_back(32'h00007FFF);
    access(1, 0, 3'b001, 32'h2, 32'h0, 0, 32'h7FFF0000, 0, 32'h0, 2);

    // reset while waiting in ACC2 of a spanning load
    push_req(1'b0, 30'h1, 4'h8, 32'h0);
    @(posedge clk); #1;
    EX_MEM_valid = 1'b1; EX_MEM_mem_read = 1'b1; EX_MEM_mem_write = 1'b0;
    EX_MEM_funct3 = 3'b001; EX_MEM_alu_out = 32'h7; dmem_ack = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hAB000000;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("acc2_addr", {dmem_req, dmem_addr}, {1'b1, 30'h2});
    reset = 1'b1;
    #1;
    check("stall_in_reset_acc2", mem_stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; EX_MEM_valid = 1'b0; EX_MEM_mem_read = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h000000CD;
    #1;
    check("after_reset", {state_dbg, dmem_req, load_valid}, 4'b0000);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_abandon", {dmem_req, load_valid, mem_stall}, 3'b000);
    end

    check("req_queue_empty", req_exp_q.size(), 0);
    check("load_queue_empty", load_exp_q.size(), 0);
    check("err_queue_empty", err_exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
